mem_bridge: RTL and testbench
=============================

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: REQ-state cycles without iBusAck before abort; legal range 1..65535.
REQ-002 iClk  input  1  clock; all state updates on its rising edge.
REQ-003 nRst  input  1  reset, asynchronous, active-low.
REQ-004 iRead  input  1  core read request, level, held until oRdy seen high.
REQ-005 iWrite  input  1  core write request, level, held until oRdy seen high.
REQ-006 iAddr  input  32  core access address.
REQ-007 iWData  input  32  core write data.
REQ-008 oRData  output  32  registered read data to core instruction/data path.
REQ-009 oRdy  output  1  core step-advance enable.
REQ-010 oBusReq  output  1  bus access request.
REQ-011 oBusWe  output  1  bus write strobe, valid with oBusReq.
REQ-012 oBusAddr  output  32  bus address, registered.
REQ-013 oBusWData  output  32  bus write data, registered.
REQ-014 iBusAck  input  1  bus completion, single-cycle pulse.
REQ-015 iBusRData  input  32  bus read data, valid with iBusAck.
REQ-016 oBusErr  output  1  sticky timeout flag.

Function
REQ-017 FSM states IDLE, REQ, DONE only; unused encodings SHALL return to IDLE.
REQ-018 IDLE: iRead|iWrite high at edge -> REQ; latch iAddr, iWData, oBusWe=iWrite into bus registers on that edge.
REQ-019 Simultaneous iRead and iWrite: write wins; read ignored, no second access.
REQ-020 REQ: oBusReq=1; bus registers stable, unchanged until leaving REQ.
REQ-021 REQ with iBusAck at edge -> DONE; on read, oRData <= iBusRData same edge; on write oRData unchanged.
REQ-022 iBusAck in IDLE or DONE ignored; no state or data change.
REQ-023 DONE: oBusReq=0, oRdy=1 for exactly one cycle; DONE -> IDLE unconditionally.
REQ-024 oRdy combinational = (IDLE && !iRead && !iWrite) || DONE; low in REQ and in IDLE while a request is presented.
REQ-025 Minimum latency: request presented cycle 0, ack in cycle 1 -> oRdy high cycle 2; back-to-back accesses every 3 cycles.
REQ-026 A request still high in the IDLE cycle after DONE starts a new access.

Reset
REQ-027 nRst low: state IDLE; oBusReq, oBusWe, oBusErr 0; oBusAddr, oBusWData, oRData 32'h0; timeout count 0; oRdy then follows REQ-024.
REQ-028 Reset mid-REQ drops oBusReq immediately (asynchronous); any later iBusAck for the aborted access ignored.

Configuration
REQ-029 Macro MEM_BRIDGE_TIMEOUT_EN defined: counter cleared on REQ entry, increments each REQ cycle without ack; count reaching TIMEOUT_CYCLES -> DONE, oBusErr<=1 (cleared only by reset), oRData<=32'hFFFF_FFFF on read.
REQ-030 Ack in the same cycle the count reaches limit: ack wins, no error.
REQ-031 Macro undefined: no counter logic, REQ waits indefinitely, oBusErr tied 0.

Structure
REQ-032 State encodings and TIMEOUT_CYCLES default live in shared header MEM.vh.
REQ-033 Timeout counter is sub-module mem_timeout (clear, enable, limit-hit output), instantiated only under MEM_BRIDGE_TIMEOUT_EN; counter width = ceil(log2(TIMEOUT_CYCLES+1)).

Verification
REQ-034 Read A=0x100, ack with 0xDEADBEEF one cycle after oBusReq rises -> oBusAddr=0x100, oBusWe=0, oRData=0xDEADBEEF, oRdy high exactly one cycle, 3-cycle total.
REQ-035 Write A=0x204 D=0x12345678, ack after 5 wait cycles -> oBusWe=1, addr/data stable all 6 REQ cycles, oRData unchanged.
REQ-036 iRead=iWrite=1, A=0x8 -> one bus write only, oBusWe=1.
REQ-037 TIMEOUT_EN, TIMEOUT_CYCLES=4, read with no ack -> DONE after 4 REQ cycles, oBusErr=1 sticky, oRData=0xFFFFFFFF; ack on 4th cycle variant -> no error.
REQ-038 nRst pulsed mid-REQ, then stray ack -> oBusReq 0 at once, FSM IDLE, oRData 0, oRdy=1 with no request.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared definitions for the core-to-bus memory bridge.
//   - state_t               : bridge FSM state encodings (IDLE, REQ, DONE)
//   - TIMEOUT_CYCLES_DEFAULT: default REQ-state wait limit before abort
//   - RDATA_TIMEOUT         : read data returned to the core on a timed-out read
//   - count_width()         : bits needed to hold a count of 0..limit
package mem_bridge_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd255;
  localparam logic [31:0] RDATA_TIMEOUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int unsigned count_width(input int unsigned limit);
    return $clog2(limit + 32'd1);
  endfunction

endpackage

// File: rtl/mem_timeout.sv
// mem_timeout: wait-cycle counter for the bridge REQ state.
// Ports:
//   iClk   - clock, rising edge
//   nRst   - asynchronous active-low reset
//   clear  - zero the count (bridge entering REQ); has priority over enable
//   enable - count this cycle (bridge in REQ without an ack)
//   hit    - this enabled cycle brings the count up to LIMIT
// Parameter LIMIT: number of un-acked REQ cycles allowed (1..65535).
module mem_timeout
  import mem_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic iClk,
  input  logic nRst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CW = count_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 32'd1);

  logic [CW-1:0] count;

  // Wait-cycle counter: cleared on REQ entry, advanced on each un-acked REQ cycle.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1'b1);
    end else begin
      count <= count;
    end
  end

  // The count reaches LIMIT on the edge that ends this cycle, so flag it now.
  assign hit = enable && (count == LAST);

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: converts level-held core read/write requests into single bus
// accesses and hands back a one-cycle step-advance (oRdy) on completion.
// Ports:
//   iClk, nRst             - clock (rising edge), asynchronous active-low reset
//   iRead, iWrite          - core requests, held until oRdy is seen high
//   iAddr, iWData          - core address / write data, latched on request
//   oRData                 - registered read data back to the core
//   oRdy                   - core step-advance enable (combinational)
//   oBusReq, oBusWe        - bus request and write strobe
//   oBusAddr, oBusWData    - registered bus address / write data
//   iBusAck, iBusRData     - bus completion pulse and read data
//   oBusErr                - sticky timeout flag
// Build option: define MEM_BRIDGE_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES
// un-acked cycles; otherwise REQ waits indefinitely and oBusErr stays 0.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iRead,
  input  logic        iWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic [31:0] oRData,
  output logic        oRdy,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWData,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData,
  output logic        oBusErr
);

  state_t state;
  state_t next_state;
  logic   req_any;
  logic   start;
  logic   ack_take;
  logic   timeout_hit;
  logic   rdy;

  assign req_any  = iRead | iWrite;
  assign start    = (state == ST_IDLE) && req_any;
  assign ack_take = (state == ST_REQ) && iBusAck;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  mem_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .iClk   (iClk),
    .nRst   (nRst),
    .clear  (start),
    .enable ((state == ST_REQ) && !iBusAck),
    .hit    (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 32'd0);
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and core ready; an ack beats a same-cycle timeout.
  always_comb begin
    next_state = ST_IDLE;
    rdy        = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy = !req_any;
        if (req_any) begin
          next_state = ST_REQ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (iBusAck || timeout_hit) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_REQ;
        end
      end
      ST_DONE: begin
        rdy        = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        rdy        = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
  end

  assign oRdy = rdy;

  // Bus-side registers: request tracks REQ, address/data/strobe latched on start.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oBusReq   <= 1'b0;
      oBusWe    <= 1'b0;
      oBusAddr  <= 32'h0000_0000;
      oBusWData <= 32'h0000_0000;
    end else begin
      oBusReq <= (next_state == ST_REQ);
      if (start) begin
        oBusWe    <= iWrite;
        oBusAddr  <= iAddr;
        oBusWData <= iWData;
      end else begin
        oBusWe    <= oBusWe;
        oBusAddr  <= oBusAddr;
        oBusWData <= oBusWData;
      end
    end
  end

  // Core read data and sticky error; writes never touch oRData.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oRData  <= 32'h0000_0000;
      oBusErr <= 1'b0;
    end else if (ack_take) begin
      oRData  <= oBusWe ? oRData : iBusRData;
      oBusErr <= oBusErr;
    end else if ((state == ST_REQ) && timeout_hit) begin
      oRData  <= oBusWe ? oRData : RDATA_TIMEOUT;
      oBusErr <= 1'b1;
    end else begin
      oRData  <= oRData;
      oBusErr <= oBusErr;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: self-checking bench for mem_bridge. Directed table vectors,
// hand-written multi-cycle sequences, and random accesses checked against a
// transaction-level model (expected REQ length, read data and error flag).
module tb_mem_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int  T_CYC = 4;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  T_CYC = 255;
  localparam bit  TO_EN = 1'b0;
`endif

  logic        iClk;
  logic        nRst;
  logic        iRead;
  logic        iWrite;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic [31:0] oRData;
  logic        oRdy;
  logic        oBusReq;
  logic        oBusWe;
  logic [31:0] oBusAddr;
  logic [31:0] oBusWData;
  logic        iBusAck;
  logic [31:0] iBusRData;
  logic        oBusErr;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_rdata;
  bit          model_err;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          wait_n;
    logic [31:0] exp_rdata;
    bit          exp_we;
    string       name;
  } vec_t;

  vec_t tbl [4];

  mem_bridge #(
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .iRead     (iRead),
    .iWrite    (iWrite),
    .iAddr     (iAddr),
    .iWData    (iWData),
    .oRData    (oRData),
    .oRdy      (oRdy),
    .oBusReq   (oBusReq),
    .oBusWe    (oBusWe),
    .oBusAddr  (oBusAddr),
    .oBusWData (oBusWData),
    .iBusAck   (iBusAck),
    .iBusRData (iBusRData),
    .oBusErr   (oBusErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete access, entered and left at a negedge in IDLE.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] brdata,
                        input bit by_ack, input int req_n,
                        input logic [31:0] exp_rdata, input bit exp_we,
                        input bit exp_err, input string nm);
    logic [31:0] old_rdata;
    old_rdata = oRData;
    iRead  = rd;
    iWrite = wr;
    iAddr  = addr;
    iWData = wdata;
    #1;
    chk({nm, ".rdy_low_idle"}, {31'd0, oRdy}, 32'd0);
    @(negedge iClk);
    iAddr  = ~addr;
    iWData = ~wdata;
    for (int k = 0; k < req_n; k++) begin
      chk({nm, ".busreq"}, {31'd0, oBusReq}, 32'd1);
      chk({nm, ".rdy_req"}, {31'd0, oRdy}, 32'd0);
      chk({nm, ".addr"}, oBusAddr, addr);
      chk({nm, ".wdata"}, oBusWData, wdata);
      chk({nm, ".we"}, {31'd0, oBusWe}, {31'd0, exp_we});
      chk({nm, ".rdata_hold"}, oRData, old_rdata);
      if (by_ack && (k == req_n - 1)) begin
        iBusAck   = 1'b1;
        iBusRData = brdata;
      end
      @(negedge iClk);
      iBusAck   = 1'b0;
      iBusRData = $urandom;
    end
    chk({nm, ".rdy_done"}, {31'd0, oRdy}, 32'd1);
    chk({nm, ".busreq_done"}, {31'd0, oBusReq}, 32'd0);
    chk({nm, ".rdata"}, oRData, exp_rdata);
    chk({nm, ".err"}, {31'd0, oBusErr}, {31'd0, exp_err});
    iRead  = 1'b0;
    iWrite = 1'b0;
    @(negedge iClk);
    chk({nm, ".rdy_idle"}, {31'd0, oRdy}, 32'd1);
    chk({nm, ".rdata_idle"}, oRData, exp_rdata);
  endtask

  // Transaction-level model: decides outcome from wait length and timeout limit.
  task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] br,
                              input int wait_n, input string nm);
    bit          by_ack;
    int          req_n;
    logic [31:0] er;
    by_ack = !TO_EN || (wait_n < T_CYC);
    req_n  = by_ack ? wait_n + 1 : T_CYC;
    er     = model_rdata;
    if (!wr) er = by_ack ? br : 32'hFFFF_FFFF;
    if (!by_ack) model_err = 1'b1;
    access(rd, wr, a, d, br, by_ack, req_n, er, wr, model_err, nm);
    model_rdata = er;
  endtask

  initial begin
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] br;
    int          wn;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0,
               32'hDEAD_BEEF, 1'b0, "rd100"};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 32'h5555_AAAA,
               (TO_EN ? 2 : 5), 32'hDEAD_BEEF, 1'b1, "wr204"};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 0,
               32'hDEAD_BEEF, 1'b1, "rdwr8"};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0BAD_F00D, 2,
               32'h0BAD_F00D, 1'b0, "rd40"};

    nRst      = 1'b0;
    iRead     = 1'b0;
    iWrite    = 1'b0;
    iAddr     = 32'h0;
    iWData    = 32'h0;
    iBusAck   = 1'b0;
    iBusRData = 32'h0;
    model_rdata = 32'h0;
    model_err   = 1'b0;
    #1;
    chk("rst.busreq", {31'd0, oBusReq}, 32'd0);
    chk("rst.we", {31'd0, oBusWe}, 32'd0);
    chk("rst.err", {31'd0, oBusErr}, 32'd0);
    chk("rst.addr", oBusAddr, 32'h0);
    chk("rst.wdata", oBusWData, 32'h0);
    chk("rst.rdata", oRData, 32'h0);
    chk("rst.rdy", {31'd0, oRdy}, 32'd1);
    @(negedge iClk);
    @(negedge iClk);
    nRst = 1'b1;

    // Ack while idle must be ignored.
    iBusAck   = 1'b1;
    iBusRData = 32'h1212_1212;
    @(negedge iClk);
    iBusAck = 1'b0;
    chk("idle_ack.rdata", oRData, 32'h0);
    chk("idle_ack.busreq", {31'd0, oBusReq}, 32'd0);
    chk("idle_ack.rdy", {31'd0, oRdy}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].brdata,
             1'b1, tbl[i].wait_n + 1, tbl[i].exp_rdata, tbl[i].exp_we, 1'b0, tbl[i].name);
      model_rdata = tbl[i].exp_rdata;
    end

    // Request held through DONE starts the next access immediately.
    iRead = 1'b1;
    iAddr = 32'h0000_0300;
    @(negedge iClk);
    chk("b2b.req1", {31'd0, oBusReq}, 32'd1);
    iBusAck   = 1'b1;
    iBusRData = 32'h1111_2222;
    @(negedge iClk);
    iBusAck = 1'b0;
    chk("b2b.rdy1", {31'd0, oRdy}, 32'd1);
    chk("b2b.rdata1", oRData, 32'h1111_2222);
    iAddr = 32'h0000_0304;
    @(negedge iClk);
    chk("b2b.rdy_idle_req", {31'd0, oRdy}, 32'd0);
    @(negedge iClk);
    chk("b2b.req2", {31'd0, oBusReq}, 32'd1);
    chk("b2b.addr2", oBusAddr, 32'h0000_0304);
    iBusAck   = 1'b1;
    iBusRData = 32'h3333_4444;
    @(negedge iClk);
    iBusAck = 1'b0;
    iRead   = 1'b0;
    chk("b2b.rdy2", {31'd0, oRdy}, 32'd1);
    chk("b2b.rdata2", oRData, 32'h3333_4444);
    model_rdata = 32'h3333_4444;
    @(negedge iClk);
    chk("b2b.rdy_end", {31'd0, oRdy}, 32'd1);

    for (int i = 0; i < 20; i++) begin
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      a  = $urandom;
      d  = $urandom;
      br = $urandom;
      wn = $urandom_range(0, 6);
      model_access(r, w, a, d, br, wn, "rand");
    end

    // Reset in the middle of REQ, followed by a stray ack.
    iRead = 1'b1;
    iAddr = 32'h0000_0500;
    @(negedge iClk);
    chk("midrst.req", {31'd0, oBusReq}, 32'd1);
    @(negedge iClk);
    nRst = 1'b0;
    #1;
    chk("midrst.busreq_async", {31'd0, oBusReq}, 32'd0);
    chk("midrst.addr", oBusAddr, 32'h0);
    iRead = 1'b0;
    @(negedge iClk);
    nRst      = 1'b1;
    iBusAck   = 1'b1;
    iBusRData = 32'hCAFE_F00D;
    @(negedge iClk);
    iBusAck = 1'b0;
    chk("midrst.rdata", oRData, 32'h0);
    chk("midrst.busreq", {31'd0, oBusReq}, 32'd0);
    chk("midrst.rdy", {31'd0, oRdy}, 32'd1);
    chk("midrst.err", {31'd0, oBusErr}, 32'd0);
    model_rdata = 32'h0;
    model_err   = 1'b0;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    model_access(1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h55AA_55AA, T_CYC - 1, "to_ack_last");
    model_access(1'b1, 1'b0, 32'h0000_0604, 32'h0, 32'h0000_0077, 100, "to_noack");
    chk("to.rdata_ff", oRData, 32'hFFFF_FFFF);
    @(negedge iClk);
    chk("to.err_sticky", {31'd0, oBusErr}, 32'd1);
`else
    model_access(1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h6060_6060, 29, "long_wait");
    chk("long.err", {31'd0, oBusErr}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
